// File: rtl/fm_pkg.sv
// Shared types and helpers for the YM2203/SAA1099 access sequencer.
// Target, access-kind and FSM encodings live here so the top and the bench agree.
package fm_pkg;

   typedef enum logic [1:0] {
      TGT_YM0 = 2'd0,
      TGT_YM1 = 2'd1,
      TGT_SAA = 2'd2
   } tgt_t;

   typedef enum logic [1:0] {
      ACC_ADDR = 2'd0,
      ACC_DATA = 2'd1,
      ACC_READ = 2'd2
   } kind_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SETUP = 2'd1,
      ST_PULSE = 2'd2,
      ST_HOLD  = 2'd3
   } state_t;

   localparam logic [4:0] CTRL_PREFIX = 5'b11111;

   typedef struct packed {
      tgt_t       tgt;
      kind_t      kind;
      logic [7:0] data;
   } access_t;

   // Control-word low bits: bit1=0 selects the SAA, otherwise bit0 picks YM0 (1) or YM1 (0).
   function automatic tgt_t ctrl_target(input logic [1:0] sel);
      if (!sel[1]) begin
         return TGT_SAA;
      end
      return sel[0] ? TGT_YM0 : TGT_YM1;
   endfunction

   // A0 polarity differs between the chips: YM A0=0 is address, SAA A0=1 is address.
   function automatic logic a0_value(input tgt_t t, input kind_t k);
      if (t == TGT_SAA) begin
         return (k == ACC_ADDR);
      end
      return (k != ACC_ADDR);
   endfunction

endpackage

// File: rtl/fm_access_timer.sv
// Phase timer: loads the phase length minus one, counts down, flags done at zero.
// One instance is reused for every phase of the access FSM.
module fm_access_timer #(
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             done
);

   logic [CNT_W-1:0] cnt_reg;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_reg <= '0;
      end else if (load) begin
         cnt_reg <= load_val;
      end else if (cnt_reg != '0) begin
         cnt_reg <= cnt_reg - 1'b1;
      end
   end

   assign done = (cnt_reg == '0);

endmodule

// File: rtl/fm_access_seq.sv
// Bus-cycle sequencer for two YM2203s and one SAA1099, fed by filtered AY-bus events.
// Strobes are registered from the next-state decode so the pins never glitch.
module fm_access_seq
   import fm_pkg::*;
#(
   parameter int YM_SETUP  = 1,
   parameter int YM_PULSE  = 14,
   parameter int YM_HOLD   = 2,
   parameter int SAA_CS2WR = 3,
   parameter int SAA_PULSE = 6,
   parameter int SAA_HOLD  = 2,
   parameter int CNT_W     = 5
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ev_wraddr,
   input  logic       ev_wrdata,
   input  logic       ev_rddata,
   input  logic [7:0] din,
   output logic       busy,
   output logic       ovf,
   output logic [1:0] ym_cs_n,
   output logic       ym_wr_n,
   output logic       ym_rd_n,
   output logic       ym_a0,
   output logic       saa_cs_n,
   output logic       saa_wr_n,
   output logic       saa_a0,
   output logic [7:0] cd_out,
   output logic       cd_oe,
   input  logic [7:0] cd_in,
   output logic [7:0] rd_data,
   output logic       rd_valid,
   output logic [1:0] tgt
);

   state_t     state_reg, state_next;
   tgt_t       tgt_reg, tgt_next;
   access_t    pend_reg, pend_next;
   logic       pend_valid_reg, pend_valid_next;
   tgt_t       cur_tgt_reg, cur_tgt_next;
   kind_t      cur_kind_reg, cur_kind_next;
   logic [7:0] cd_out_reg, cd_out_next;
   logic       ym_a0_reg, ym_a0_next;
   logic       saa_a0_reg, saa_a0_next;
   logic [7:0] rd_data_reg, rd_data_next;
   logic       rd_valid_reg, rd_valid_next;
   logic       ovf_reg, ovf_next;
   logic [1:0] ym_cs_n_reg, ym_cs_n_next;
   logic       ym_wr_n_reg, ym_wr_n_next;
   logic       ym_rd_n_reg, ym_rd_n_next;
   logic       saa_cs_n_reg, saa_cs_n_next;
   logic       saa_wr_n_reg, saa_wr_n_next;
   logic       cd_oe_reg, cd_oe_next;
   logic [1:0] ym_cs_sel;

   logic             timer_load;
   logic [CNT_W-1:0] timer_val;
   logic             timer_done;

   logic    ev_any, is_ctrl, ev_acc, take;
   kind_t   ev_kind;
   access_t new_acc, take_acc;

   function automatic logic [CNT_W-1:0] phase_last(input state_t s, input tgt_t t);
      int n;
      n = 1;
      case (s)
         ST_SETUP: n = (t == TGT_SAA) ? SAA_CS2WR : YM_SETUP;
         ST_PULSE: n = (t == TGT_SAA) ? SAA_PULSE : YM_PULSE;
         ST_HOLD:  n = (t == TGT_SAA) ? SAA_HOLD  : YM_HOLD;
         default:  n = 1;
      endcase
      return CNT_W'(n - 1);
   endfunction

   fm_access_timer #(.CNT_W(CNT_W)) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (timer_load),
      .load_val (timer_val),
      .done     (timer_done)
   );

   // Only the winning event matters; a control write that loses priority is ignored too.
   assign ev_any  = ev_rddata | ev_wrdata | ev_wraddr;
   assign is_ctrl = ev_wraddr & ~ev_rddata & ~ev_wrdata & (din[7:3] == CTRL_PREFIX);
   assign ev_acc  = ev_any & ~is_ctrl;
   assign ev_kind = ev_rddata ? ACC_READ : (ev_wrdata ? ACC_DATA : ACC_ADDR);
   assign new_acc = '{tgt: tgt_reg, kind: ev_kind, data: din};

   always_comb begin
      state_next      = state_reg;
      tgt_next        = tgt_reg;
      pend_next       = pend_reg;
      pend_valid_next = pend_valid_reg;
      cur_tgt_next    = cur_tgt_reg;
      cur_kind_next   = cur_kind_reg;
      cd_out_next     = cd_out_reg;
      ym_a0_next      = ym_a0_reg;
      saa_a0_next     = saa_a0_reg;
      rd_data_next    = rd_data_reg;
      rd_valid_next   = 1'b0;
      ovf_next        = 1'b0;
      timer_load      = 1'b0;
      timer_val       = '0;
      take            = 1'b0;
      take_acc        = new_acc;

      if (is_ctrl) begin
         tgt_next = ctrl_target(din[1:0]);
      end

      case (state_reg)
         ST_IDLE: begin
            // The pending entry goes first; a fresh event refills the slot it frees.
            if (pend_valid_reg) begin
               take            = 1'b1;
               take_acc        = pend_reg;
               pend_valid_next = ev_acc;
               if (ev_acc) begin
                  pend_next = new_acc;
               end
            end else if (ev_acc) begin
               take = 1'b1;
            end
         end
         ST_SETUP: begin
            if (timer_done) begin
               state_next = ST_PULSE;
               timer_load = 1'b1;
               timer_val  = phase_last(ST_PULSE, cur_tgt_reg);
            end
         end
         ST_PULSE: begin
            if (timer_done) begin
               state_next = ST_HOLD;
               timer_load = 1'b1;
               timer_val  = phase_last(ST_HOLD, cur_tgt_reg);
               if (cur_kind_reg == ACC_READ) begin
                  rd_data_next  = cd_in;
                  rd_valid_next = 1'b1;
               end
            end
         end
         ST_HOLD: begin
            if (timer_done) begin
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase

      if ((state_reg != ST_IDLE) && ev_acc) begin
         if (!pend_valid_reg) begin
            pend_next       = new_acc;
            pend_valid_next = 1'b1;
         end else begin
            ovf_next = 1'b1;
         end
      end

      if (take) begin
         // The SAA has no read path; answer at once without touching the bus.
         if ((take_acc.tgt == TGT_SAA) && (take_acc.kind == ACC_READ)) begin
            rd_data_next  = 8'hFF;
            rd_valid_next = 1'b1;
         end else begin
            state_next    = ST_SETUP;
            cur_tgt_next  = take_acc.tgt;
            cur_kind_next = take_acc.kind;
            cd_out_next   = take_acc.data;
            timer_load    = 1'b1;
            timer_val     = phase_last(ST_SETUP, take_acc.tgt);
            if (take_acc.tgt == TGT_SAA) begin
               saa_a0_next = a0_value(take_acc.tgt, take_acc.kind);
            end else begin
               ym_a0_next = a0_value(take_acc.tgt, take_acc.kind);
            end
         end
      end
   end

   for (genvar gi = 0; gi < 2; gi++) begin : g_ym_cs
      localparam tgt_t SEL = (gi == 0) ? TGT_YM0 : TGT_YM1;
      assign ym_cs_sel[gi] = (state_next == ST_PULSE) && (cur_tgt_next == SEL);
   end

   always_comb begin
      ym_cs_n_next  = ~ym_cs_sel;
      ym_wr_n_next  = 1'b1;
      ym_rd_n_next  = 1'b1;
      saa_cs_n_next = 1'b1;
      saa_wr_n_next = 1'b1;
      cd_oe_next    = (state_next != ST_IDLE) && (cur_kind_next != ACC_READ);
      if (cur_tgt_next == TGT_SAA) begin
         saa_cs_n_next = !((state_next == ST_SETUP) || (state_next == ST_PULSE));
         saa_wr_n_next = !(state_next == ST_PULSE);
      end else if (state_next == ST_PULSE) begin
         ym_wr_n_next = (cur_kind_next == ACC_READ);
         ym_rd_n_next = (cur_kind_next != ACC_READ);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg      <= ST_IDLE;
         tgt_reg        <= TGT_YM0;
         pend_reg       <= '{tgt: TGT_YM0, kind: ACC_ADDR, data: 8'h00};
         pend_valid_reg <= 1'b0;
         cur_tgt_reg    <= TGT_YM0;
         cur_kind_reg   <= ACC_ADDR;
         cd_out_reg     <= 8'hFF;
         ym_a0_reg      <= 1'b0;
         saa_a0_reg     <= 1'b0;
         rd_data_reg    <= 8'hFF;
         rd_valid_reg   <= 1'b0;
         ovf_reg        <= 1'b0;
         ym_cs_n_reg    <= 2'b11;
         ym_wr_n_reg    <= 1'b1;
         ym_rd_n_reg    <= 1'b1;
         saa_cs_n_reg   <= 1'b1;
         saa_wr_n_reg   <= 1'b1;
         cd_oe_reg      <= 1'b0;
      end else begin
         state_reg      <= state_next;
         tgt_reg        <= tgt_next;
         pend_reg       <= pend_next;
         pend_valid_reg <= pend_valid_next;
         cur_tgt_reg    <= cur_tgt_next;
         cur_kind_reg   <= cur_kind_next;
         cd_out_reg     <= cd_out_next;
         ym_a0_reg      <= ym_a0_next;
         saa_a0_reg     <= saa_a0_next;
         rd_data_reg    <= rd_data_next;
         rd_valid_reg   <= rd_valid_next;
         ovf_reg        <= ovf_next;
         ym_cs_n_reg    <= ym_cs_n_next;
         ym_wr_n_reg    <= ym_wr_n_next;
         ym_rd_n_reg    <= ym_rd_n_next;
         saa_cs_n_reg   <= saa_cs_n_next;
         saa_wr_n_reg   <= saa_wr_n_next;
         cd_oe_reg      <= cd_oe_next;
      end
   end

   assign busy     = (state_reg != ST_IDLE);
   assign ovf      = ovf_reg;
   assign ym_cs_n  = ym_cs_n_reg;
   assign ym_wr_n  = ym_wr_n_reg;
   assign ym_rd_n  = ym_rd_n_reg;
   assign ym_a0    = ym_a0_reg;
   assign saa_cs_n = saa_cs_n_reg;
   assign saa_wr_n = saa_wr_n_reg;
   assign saa_a0   = saa_a0_reg;
   assign cd_out   = cd_out_reg;
   assign cd_oe    = cd_oe_reg;
   assign rd_data  = rd_data_reg;
   assign rd_valid = rd_valid_reg;
   assign tgt      = tgt_reg;

endmodule

// File: tb/tb_fm_access_seq.sv
// Directed and randomized checks of fm_access_seq against a timeline model:
// each access is a start cycle plus phase offsets, the pending slot is one entry.
`timescale 1ns/1ps
module tb_fm_access_seq;

   localparam int YS = 1, YP = 14, YH = 2;
   localparam int SC = 3, SP = 6, SH = 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ev_wraddr = 1'b0, ev_wrdata = 1'b0, ev_rddata = 1'b0;
   logic [7:0] din = 8'h00, cd_in = 8'h00;
   logic       busy, ovf, ym_wr_n, ym_rd_n, ym_a0, saa_cs_n, saa_wr_n, saa_a0, cd_oe, rd_valid;
   logic [1:0] ym_cs_n, tgt;
   logic [7:0] cd_out, rd_data;

   fm_access_seq dut (
      .clk(clk), .rst_n(rst_n), .ev_wraddr(ev_wraddr), .ev_wrdata(ev_wrdata),
      .ev_rddata(ev_rddata), .din(din), .busy(busy), .ovf(ovf), .ym_cs_n(ym_cs_n),
      .ym_wr_n(ym_wr_n), .ym_rd_n(ym_rd_n), .ym_a0(ym_a0), .saa_cs_n(saa_cs_n),
      .saa_wr_n(saa_wr_n), .saa_a0(saa_a0), .cd_out(cd_out), .cd_oe(cd_oe),
      .cd_in(cd_in), .rd_data(rd_data), .rd_valid(rd_valid), .tgt(tgt)
   );

   always #9 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int cyc = 0;

   // Model: target 0=YM0 1=YM1 2=SAA, kind 0=addr 1=data 2=read.
   bit         m_act;
   int         m_start, m_end, m_tgt_run, m_kind_run;
   bit         m_pv;
   int         m_p_tgt, m_p_kind;
   logic [7:0] m_p_data;
   int         m_tgt;
   logic [7:0] m_cd_out, m_rd_data;
   bit         m_ym_a0, m_saa_a0;
   int         m_rdv_cyc, m_ovf_cyc;

   int n_busy, n_wr, n_rd, n_scs, n_swr, n_rdv, n_ovf, n_cs0, n_cs1, n_oe, first_wr;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic bit m_busy(input int c);
      return m_act && (c >= m_start) && (c <= m_end);
   endfunction

   task automatic m_reset();
      m_act = 0; m_pv = 0; m_tgt = 0; m_cd_out = 8'hFF; m_rd_data = 8'hFF;
      m_ym_a0 = 0; m_saa_a0 = 0; m_rdv_cyc = -1; m_ovf_cyc = -1;
      m_start = 0; m_end = -1; m_tgt_run = 0; m_kind_run = 0;
   endtask

   task automatic m_begin(input int t, input int k, input logic [7:0] d, input int n);
      if (t == 2 && k == 2) begin
         m_rd_data = 8'hFF;
         m_rdv_cyc = n;
      end else begin
         m_act = 1; m_start = n;
         m_end = n + ((t == 2) ? (SC + SP + SH) : (YS + YP + YH)) - 1;
         m_tgt_run = t; m_kind_run = k; m_cd_out = d;
         if (t == 2) m_saa_a0 = (k == 0);
         else        m_ym_a0 = (k != 0);
      end
   endtask

   task automatic model_edge();
      int n, k;
      bit ctrl, acc;
      n = cyc + 1;
      if (!rst_n) begin
         m_reset();
         return;
      end
      if (m_busy(cyc) && m_tgt_run != 2 && m_kind_run == 2 && cyc == m_start + YS + YP - 1) begin
         m_rd_data = cd_in;
         m_rdv_cyc = n;
      end
      k    = ev_rddata ? 2 : (ev_wrdata ? 1 : 0);
      ctrl = ev_wraddr && !ev_rddata && !ev_wrdata && (din[7:3] == 5'b11111);
      acc  = (ev_wraddr || ev_wrdata || ev_rddata) && !ctrl;
      if (!m_busy(cyc)) begin
         if (m_pv) begin
            m_pv = 0;
            m_begin(m_p_tgt, m_p_kind, m_p_data, n);
            if (acc) begin m_pv = 1; m_p_tgt = m_tgt; m_p_kind = k; m_p_data = din; end
         end else if (acc) begin
            m_begin(m_tgt, k, din, n);
         end
      end else if (acc) begin
         if (!m_pv) begin m_pv = 1; m_p_tgt = m_tgt; m_p_kind = k; m_p_data = din; end
         else m_ovf_cyc = n;
      end
      if (ctrl) m_tgt = !din[1] ? 2 : (din[0] ? 0 : 1);
   endtask

   function automatic logic [29:0] m_expect(input int c);
      logic [1:0] cs;
      logic wr, rd, scs, swr, oe, bz;
      int o;
      cs = 2'b11; wr = 1; rd = 1; scs = 1; swr = 1; oe = 0; bz = 0;
      if (m_busy(c)) begin
         bz = 1;
         o  = c - m_start;
         oe = (m_kind_run != 2);
         if (m_tgt_run == 2) begin
            scs = !(o < SC + SP);
            swr = !(o >= SC && o < SC + SP);
         end else if (o >= YS && o < YS + YP) begin
            cs[m_tgt_run] = 1'b0;
            if (m_kind_run == 2) rd = 0;
            else                 wr = 0;
         end
      end
      return {bz, (c == m_ovf_cyc), cs, wr, rd, m_ym_a0, scs, swr, m_saa_a0, oe,
              (c == m_rdv_cyc), 2'(m_tgt), m_cd_out, m_rd_data};
   endfunction

   task automatic mclr();
      n_busy = 0; n_wr = 0; n_rd = 0; n_scs = 0; n_swr = 0; n_rdv = 0;
      n_ovf = 0; n_cs0 = 0; n_cs1 = 0; n_oe = 0; first_wr = -1;
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      cyc++;
      @(negedge clk);
      chk("cycle", {2'b00, busy, ovf, ym_cs_n, ym_wr_n, ym_rd_n, ym_a0, saa_cs_n, saa_wr_n,
                    saa_a0, cd_oe, rd_valid, tgt, cd_out, rd_data}, {2'b00, m_expect(cyc)});
      if (busy) n_busy++;
      if (!ym_wr_n) n_wr++;
      if (!ym_rd_n) n_rd++;
      if (!saa_cs_n) n_scs++;
      if (!saa_wr_n) n_swr++;
      if (rd_valid) n_rdv++;
      if (ovf) n_ovf++;
      if (cd_oe) n_oe++;
      if (ym_cs_n == 2'b10) n_cs0++;
      if (ym_cs_n == 2'b01) n_cs1++;
      if (!ym_wr_n && first_wr < 0) first_wr = cyc;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic ev(input logic wa, input logic wd, input logic rd, input logic [7:0] v);
      $display("[TB] cyc %0d event wa=%0b wd=%0b rd=%0b din=%02h tgt=%0d", cyc, wa, wd, rd, v, m_tgt);
      ev_wraddr = wa; ev_wrdata = wd; ev_rddata = rd; din = v;
      tick();
      ev_wraddr = 0; ev_wrdata = 0; ev_rddata = 0;
   endtask

   initial begin
      int ev_cyc, r;
      logic [7:0] v;
      m_reset();
      mclr();

      // Reset state
      rst_n = 0; idle(2); rst_n = 1; idle(1);
      chk("reset_out", {2'b00, busy, ovf, ym_cs_n, ym_wr_n, ym_rd_n, ym_a0, saa_cs_n, saa_wr_n,
                        saa_a0, cd_oe, rd_valid, tgt, cd_out, rd_data},
          {2'b00, 1'b0, 1'b0, 2'b11, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'hFF, 8'hFF});

      // 1: YM0 address write
      mclr(); ev_cyc = cyc;
      ev(1, 0, 0, 8'h07);
      chk("t1_cd_out", cd_out, 8'h07);
      chk("t1_ym_a0", ym_a0, 0);
      idle(24);
      chk("t1_wr_cycles", n_wr, 14);
      chk("t1_cs_ym0", n_cs0, 14);
      chk("t1_busy", n_busy, 17);
      chk("t1_start", first_wr - ev_cyc, 2);

      // 2: YM1 data write, then SAA address write
      mclr();
      ev(1, 0, 0, 8'hFE);
      ev(0, 1, 0, 8'h3C);
      idle(24);
      chk("t2_tgt_ym1", tgt, 1);
      chk("t2_cs_ym1", n_cs1, 14);
      chk("t2_ym_a0", ym_a0, 1);
      mclr();
      ev(1, 0, 0, 8'hFD);
      ev(1, 0, 0, 8'h1C);
      idle(16);
      chk("t2_tgt_saa", tgt, 2);
      chk("t2_saa_a0", saa_a0, 1);
      chk("t2_saa_cs", n_scs, 9);
      chk("t2_saa_wr", n_swr, 6);
      chk("t2_no_ym_wr", n_wr, 0);

      // 3: reads from YM0 and SAA
      ev(1, 0, 0, 8'hFF);
      cd_in = 8'hA5;
      mclr();
      ev(0, 0, 1, 8'h00);
      idle(24);
      chk("t3_rd_cycles", n_rd, 14);
      chk("t3_rdv_count", n_rdv, 1);
      chk("t3_rd_data", rd_data, 8'hA5);
      chk("t3_no_oe", n_oe, 0);
      ev(1, 0, 0, 8'hFD);
      mclr();
      ev(0, 0, 1, 8'h00);
      chk("t3_saa_rdv", rd_valid, 1);
      chk("t3_saa_data", rd_data, 8'hFF);
      idle(3);
      chk("t3_saa_busy", n_busy, 0);

      // 4: three writes 3 cycles apart
      ev(1, 0, 0, 8'hFF);
      mclr();
      ev(0, 1, 0, 8'h11); idle(2);
      ev(0, 1, 0, 8'h22); idle(2);
      ev(0, 1, 0, 8'h33);
      idle(40);
      chk("t4_ovf", n_ovf, 1);
      chk("t4_wr_cycles", n_wr, 28);
      chk("t4_busy", n_busy, 34);
      chk("t4_last_data", cd_out, 8'h22);

      // 5: read wins over same-cycle data write
      mclr();
      ev(0, 1, 1, 8'h44);
      idle(24);
      chk("t5_rd_cycles", n_rd, 14);
      chk("t5_no_wr", n_wr, 0);

      // 6: reset during PULSE with a pending access
      ev(1, 0, 0, 8'hFE);
      ev(0, 1, 0, 8'h55);
      idle(1);
      ev(0, 1, 0, 8'h66);
      idle(3);
      chk("t6_in_pulse", {ym_cs_n, ym_wr_n}, {2'b01, 1'b0});
      rst_n = 0; idle(1); rst_n = 1;
      chk("t6_strobes", {busy, ym_cs_n, ym_wr_n, ym_rd_n, saa_cs_n, saa_wr_n}, 7'b0111111);
      chk("t6_tgt", tgt, 0);
      mclr();
      idle(25);
      chk("t6_pend_cleared", n_busy, 0);

      // Randomized traffic, checked cycle by cycle against the model
      for (int i = 0; i < 900; i++) begin
         cd_in = 8'($urandom);
         if ($urandom_range(0, 3) == 0) begin
            r = int'($urandom_range(1, 7));
            v = 8'($urandom);
            if ($urandom_range(0, 3) == 0) v[7:3] = 5'b11111;
            ev(r[0], r[1], r[2], v);
         end else begin
            tick();
         end
      end
      idle(40);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
